adc_frame_packer: RTL and testbench



---
 rtl/adc_frame_packer.sv | 224 ++++++++++++++++++++++
 tb/tb_adc_frame_packer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: groups kept ADC samples into fixed-length frames,
// buffers them in a sample FIFO and streams header + FRAME_LEN samples
// on a valid/ready output. A frame is accepted only if the FIFO has room
// for all of it when it starts; otherwise the whole frame is dropped.
// Optional feature macro: TRIANGLE_CHECK_EN (sample step checker).
//
// Output FSM states:
//   O_IDLE | no frame ready, out_valid low
//   O_HDR  | presenting the frame header word
//   O_DATA | presenting FIFO samples, beat 0..FRAME_LEN-1
module adc_frame_packer #(
   parameter int WIDTH      = 32,
   parameter int FRAME_LEN  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int DECIM      = 1,
   parameter int STEP       = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             overflow,
   output logic [15:0]      drop_count,
   output logic [15:0]      frame_seq,
   output logic             check_err
);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;
   localparam int IW       = $clog2(FRAME_LEN);
   localparam int DW       = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int HQ_DEPTH = FIFO_DEPTH / FRAME_LEN + 1;
   localparam int HAW      = $clog2(HQ_DEPTH);
   localparam int HCW      = $clog2(HQ_DEPTH + 1);

   localparam logic [1:0] O_IDLE = 2'd0;
   localparam logic [1:0] O_HDR  = 2'd1;
   localparam logic [1:0] O_DATA = 2'd2;

   logic [DW-1:0]    dcnt;
   logic [IW-1:0]    icnt;
   logic             frame_ok;
   logic [15:0]      hdr_seq;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic [15:0]      hq [HQ_DEPTH];
   logic [HAW-1:0]   hq_wr, hq_rd;
   logic [HCW-1:0]   hq_count;
   logic [1:0]       o_state;
   logic [IW-1:0]    beat;

   logic kept, frame_start, room, wr_en, last_in, hq_push, hq_pop, rd_en, last_beat;
   logic [CW-1:0] fifo_free;

   assign kept        = enable && (dcnt == '0);
   assign frame_start = kept && (icnt == '0);
   assign fifo_free   = CW'(FIFO_DEPTH) - count;
   assign room        = fifo_free >= CW'(FRAME_LEN);
   assign wr_en       = kept && (frame_start ? room : frame_ok);
   assign last_in     = (icnt == IW'(FRAME_LEN - 1));
   assign hq_push     = wr_en && last_in;
   assign hq_pop      = (o_state == O_HDR) && out_ready;
   assign rd_en       = (o_state == O_DATA) && out_ready;
   assign last_beat   = (beat == IW'(FRAME_LEN - 1));

   // Decimation, frame position, accept/drop decision and sequence numbering
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt       <= '0;
         icnt       <= '0;
         frame_ok   <= 1'b0;
         hdr_seq    <= '0;
         frame_seq  <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (enable)
            dcnt <= (dcnt == DW'(DECIM - 1)) ? '0 : dcnt + 1'b1;
         if (kept) begin
            icnt <= last_in ? '0 : icnt + 1'b1;
            if (frame_start) begin
               frame_seq <= frame_seq + 16'd1;
               if (room) begin
                  frame_ok <= 1'b1;
                  hdr_seq  <= frame_seq;
               end else begin
                  frame_ok <= 1'b0;
                  overflow <= 1'b1;
                  if (drop_count != 16'hFFFF)
                     drop_count <= drop_count + 16'd1;
               end
            end
         end
      end
   end

   // Sample storage; emptiness is tracked by the pointers/count only
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= sample;
   end

   // FIFO pointers and occupancy; simultaneous write and read leave count unchanged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Header storage for completed frames
   always_ff @(posedge clk) begin
      if (hq_push)
         hq[hq_wr] <= hdr_seq;
   end

   // Header queue pointers; depth is not a power of two so wrap explicitly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hq_wr    <= '0;
         hq_rd    <= '0;
         hq_count <= '0;
      end else begin
         if (hq_push) hq_wr <= (hq_wr == HAW'(HQ_DEPTH - 1)) ? '0 : hq_wr + 1'b1;
         if (hq_pop)  hq_rd <= (hq_rd == HAW'(HQ_DEPTH - 1)) ? '0 : hq_rd + 1'b1;
         case ({hq_push, hq_pop})
            2'b10:   hq_count <= hq_count + 1'b1;
            2'b01:   hq_count <= hq_count - 1'b1;
            default: hq_count <= hq_count;
         endcase
      end
   end

   // Output sequencing: header, then FRAME_LEN samples, back-to-back if queued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_state <= O_IDLE;
         beat    <= '0;
      end else begin
         case (o_state)
            O_IDLE: if (hq_count != '0) o_state <= O_HDR;
            O_HDR: begin
               if (out_ready) begin
                  o_state <= O_DATA;
                  beat    <= '0;
               end
            end
            O_DATA: begin
               if (out_ready) begin
                  if (last_beat) begin
                     beat    <= '0;
                     o_state <= (hq_count != '0) ? O_HDR : O_IDLE;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            default: o_state <= O_IDLE;
         endcase
      end
   end

   // Output word selection; all outputs are zero outside a frame
   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      case (o_state)
         O_HDR: begin
            out_valid      = 1'b1;
            out_data[31:0] = {16'hADC0, hq[hq_rd]};
         end
         O_DATA: begin
            out_valid = 1'b1;
            out_data  = mem[rd_ptr];
            out_last  = last_beat;
         end
         default: ;
      endcase
   end

`ifdef TRIANGLE_CHECK_EN
   localparam logic [WIDTH-1:0] STEP_P = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] STEP_N = '0 - WIDTH'(STEP);

   logic [WIDTH-1:0] prev;
   logic             prev_ok;
   logic [WIDTH-1:0] diff;

   assign diff = sample - prev;

   // Step checker between consecutive kept samples; an enable gap restarts it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev      <= '0;
         prev_ok   <= 1'b0;
         check_err <= 1'b0;
      end else if (!enable) begin
         prev_ok <= 1'b0;
      end else if (kept) begin
         prev    <= sample;
         prev_ok <= 1'b1;
         if (prev_ok && diff != STEP_P && diff != STEP_N && diff != '0)
            check_err <= 1'b1;
      end
   end
`else
   assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: instance A (DECIM=1) and
// instance B (DECIM=3), both FRAME_LEN=4, FIFO_DEPTH=8.
module tb_adc_frame_packer;
   logic        clk = 1'b0;
   logic        reset;
   logic        en_a, en_b, rdy_a, rdy_b;
   logic [31:0] smp_a, smp_b;
   logic [31:0] dat_a, dat_b;
   logic        val_a, val_b, last_a, last_b, ovf_a, ovf_b, cerr_a, cerr_b;
   logic [15:0] drop_a, drop_b, seq_a, seq_b;

   int n_checks = 0;
   int n_pass   = 0;
   logic [32:0] q_a[$];
   logic [32:0] q_b[$];

   always #5 clk = ~clk;

   adc_frame_packer #(.WIDTH(32), .FRAME_LEN(4), .FIFO_DEPTH(8), .DECIM(1), .STEP(1)) dut_a (
      .clk(clk), .reset(reset), .enable(en_a), .sample(smp_a),
      .out_data(dat_a), .out_valid(val_a), .out_ready(rdy_a), .out_last(last_a),
      .overflow(ovf_a), .drop_count(drop_a), .frame_seq(seq_a), .check_err(cerr_a));

   adc_frame_packer #(.WIDTH(32), .FRAME_LEN(4), .FIFO_DEPTH(8), .DECIM(3), .STEP(1)) dut_b (
      .clk(clk), .reset(reset), .enable(en_b), .sample(smp_b),
      .out_data(dat_b), .out_valid(val_b), .out_ready(rdy_b), .out_last(last_b),
      .overflow(ovf_b), .drop_count(drop_b), .frame_seq(seq_b), .check_err(cerr_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic exp_frame(input bit is_b, input logic [15:0] seq, input logic [31:0] s0,
                            input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] s3);
      logic [32:0] e [5];
      e[0] = {1'b0, 16'hADC0, seq};
      e[1] = {1'b0, s0};
      e[2] = {1'b0, s1};
      e[3] = {1'b0, s2};
      e[4] = {1'b1, s3};
      for (int i = 0; i < 5; i++) begin
         if (is_b) q_b.push_back(e[i]);
         else      q_a.push_back(e[i]);
      end
   endtask

   task automatic send_a(input logic [31:0] s);
      en_a = 1'b1; smp_a = s;
      @(posedge clk); #1;
   endtask

   task automatic send_b(input logic [31:0] s);
      en_b = 1'b1; smp_b = s;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      en_a = 1'b0; en_b = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Monitor A: every accepted word is popped from the expectation queue
   always @(negedge clk) begin
      if (!reset && val_a && rdy_a) begin
         if (q_a.size() == 0) begin
            n_checks++;
            $display("FAIL a_unexpected_word: got %h expected no word", dat_a);
         end else begin
            logic [32:0] e;
            e = q_a.pop_front();
            chk("a_data", dat_a, e[31:0]);
            chk("a_last", {31'd0, last_a}, {31'd0, e[32]});
         end
      end
   end

   // Monitor B
   always @(negedge clk) begin
      if (!reset && val_b && rdy_b) begin
         if (q_b.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected_word: got %h expected no word", dat_b);
         end else begin
            logic [32:0] e;
            e = q_b.pop_front();
            chk("b_data", dat_b, e[31:0]);
            chk("b_last", {31'd0, last_b}, {31'd0, e[32]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic exp_err;
`ifdef TRIANGLE_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      reset = 1'b1; en_a = 0; en_b = 0; smp_a = 0; smp_b = 0; rdy_a = 1; rdy_b = 1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_valid", {31'd0, val_a}, 0);
      chk("rst_data", dat_a, 0);
      chk("rst_last", {31'd0, last_a}, 0);
      chk("rst_overflow", {31'd0, ovf_a}, 0);
      chk("rst_drop", {16'd0, drop_a}, 0);
      chk("rst_seq", {16'd0, seq_a}, 0);
      chk("rst_check_err", {31'd0, cerr_a}, 0);

      // basic frame, out_valid one cycle after last write
      exp_frame(0, 16'd0, 10, 11, 12, 13);
      send_a(10); send_a(11); send_a(12); send_a(13);
      en_a = 1'b0;
      chk("t1_valid_low", {31'd0, val_a}, 0);
      @(posedge clk); #1;
      chk("t1_valid_rise", {31'd0, val_a}, 1);
      idle(8);
      chk("t1_seq", {16'd0, seq_a}, 1);
      chk("t1_check_err", {31'd0, cerr_a}, 0);

      // reset while in O_DATA at beat 2
      rdy_a = 1'b0;
      exp_frame(0, 16'd1, 20, 21, 22, 23);
      send_a(20); send_a(21); send_a(22); send_a(23);
      en_a = 1'b0;
      for (int i = 0; i < 20 && !val_a; i++) begin @(posedge clk); #1; end
      chk("t5_wait_valid", {31'd0, val_a}, 1);
      rdy_a = 1'b1;
      repeat (3) @(posedge clk);
      #1 rdy_a = 1'b0;
      chk("t5_beat2_data", dat_a, 22);
      chk("t5_beat2_last", {31'd0, last_a}, 0);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_valid", {31'd0, val_a}, 0);
      chk("t5_rst_data", dat_a, 0);
      chk("t5_rst_seq", {16'd0, seq_a}, 0);
      q_a.delete();
      @(posedge clk); #1 reset = 1'b0;

      // stalled consumer: two frames stored, three dropped
      exp_frame(0, 16'd0, 100, 101, 102, 103);
      exp_frame(0, 16'd1, 104, 105, 106, 107);
      for (int i = 0; i < 20; i++) send_a(100 + i);
      en_a = 1'b0; rdy_a = 1'b1;
      idle(15);
      chk("t2_drop", {16'd0, drop_a}, 3);
      chk("t2_overflow", {31'd0, ovf_a}, 1);
      chk("t2_seq", {16'd0, seq_a}, 5);
      exp_frame(0, 16'd5, 200, 201, 202, 203);
      send_a(200); send_a(201); send_a(202); send_a(203);
      idle(8);

      // enable gap pauses the frame without dropping it
      exp_frame(0, 16'd6, 300, 301, 302, 303);
      send_a(300); send_a(301);
      idle(5);
      send_a(302); send_a(303);
      idle(8);
      chk("t4_drop", {16'd0, drop_a}, 3);
      chk("t4_seq", {16'd0, seq_a}, 7);

      // step checker: 5,6,7,7,6 fine, 9 breaks the step
      exp_frame(0, 16'd7, 5, 6, 7, 7);
      send_a(5); send_a(6); send_a(7); send_a(7); send_a(6);
      chk("t6_err_before", {31'd0, cerr_a}, 0);
      send_a(9);
      chk("t6_err_at_9", {31'd0, cerr_a}, {31'd0, exp_err});
      idle(3);
      chk("t6_err_sticky", {31'd0, cerr_a}, {31'd0, exp_err});
      idle(8);

      // decimation by 3 on instance B
      exp_frame(1, 16'd0, 0, 3, 6, 9);
      for (int i = 0; i < 12; i++) send_b(i);
      idle(10);
      chk("t3_seq", {16'd0, seq_b}, 1);
      chk("t3_drop", {16'd0, drop_b}, 0);

      chk("a_queue_empty", q_a.size(), 0);
      chk("b_queue_empty", q_b.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
